// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the data-memory responder state type.
package rv32i_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } rsp_state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: access legality, store byte mask/replication and
// little-endian load extraction with sign/zero extension.
module dmem_lane_unit
   import rv32i_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS) + 2;

   logic [1:0]  lane;
   logic [31:0] shifted;
   logic        legal;
   logic        misalign;
   logic        oor;

   assign lane    = addr_i[1:0];
   assign shifted = rword_i >> {lane, 3'b000};
   assign oor     = |addr_i[31:ADDR_W];

   always_comb begin
      legal    = 1'b0;
      misalign = 1'b0;
      wmask_o  = 4'b0000;
      wword_o  = 32'd0;
      rdata_o  = 32'd0;
      case (funct3_i)
         F3_LB: begin
            legal   = 1'b1;
            wmask_o = 4'b0001 << lane;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_LH: begin
            legal    = 1'b1;
            misalign = addr_i[0];
            wmask_o  = 4'b0011 << lane;
            wword_o  = {2{wdata_i[15:0]}};
            rdata_o  = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_LW: begin
            legal    = 1'b1;
            misalign = |lane;
            wmask_o  = 4'b1111;
            wword_o  = wdata_i;
            rdata_o  = shifted;
         end
         F3_LBU: begin
            legal   = !we_i;
            rdata_o = {24'd0, shifted[7:0]};
         end
         F3_LHU: begin
            legal    = !we_i;
            misalign = addr_i[0];
            rdata_o  = {16'd0, shifted[15:0]};
         end
         default: ;
      endcase
      err_o = !legal || misalign || oor;
      // A faulting or load access never writes; stores and faults return zero.
      if (err_o || !we_i) wmask_o = 4'b0000;
      if (err_o || we_i)  rdata_o = 32'd0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder for an RV32I core: one outstanding request,
// fixed latency, storage committed/sampled on the edge that enters RESP.
module dmem_responder
   import rv32i_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output rsp_state_e  dbg_state_o
);

   // Handshakes: a request transfers on an edge where req_valid && req_ready;
   // a response transfers on an edge where rsp_valid && rsp_ready.
   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   rsp_state_e  state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        rsp_valid_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             commit;
   logic             op_we;
   logic [2:0]       op_funct3;
   logic [31:0]      op_addr;
   logic [31:0]      op_wdata;
   logic [IDX_W-1:0] idx;
   logic [3:0]       lane_wmask;
   logic [31:0]      lane_wword;
   logic [31:0]      lane_rdata;
   logic             lane_err;

   assign accept = (state_q == ST_IDLE) && req_valid;
   assign commit = (accept && (WAIT_CYCLES == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));

   // With no wait states the commit edge is the accept edge, so use live inputs.
   assign op_we     = (state_q == ST_IDLE) ? req_we     : we_q;
   assign op_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
   assign op_addr   = (state_q == ST_IDLE) ? req_addr   : addr_q;
   assign op_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
   assign idx       = op_addr[IDX_W+1:2];

   dmem_lane_unit #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
      .we_i     (op_we),
      .funct3_i (op_funct3),
      .addr_i   (op_addr),
      .wdata_i  (op_wdata),
      .rword_i  (mem[idx]),
      .wmask_o  (lane_wmask),
      .wword_o  (lane_wword),
      .rdata_o  (lane_rdata),
      .err_o    (lane_err)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  cnt_q    <= CNT_INIT;
                  state_q  <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) state_q <= ST_RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            ST_RESP: begin
               // rsp_valid rises one cycle after entering RESP.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (commit) begin
            rdata_q <= lane_rdata;
            err_q   <= lane_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (commit && lane_wmask[b]) mem[idx][8*b +: 8] <= lane_wword[8*b +: 8];
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign dbg_state_o = state_q;

endmodule
